// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU front end.
package tiny_cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_HI = 2'd1,
      RD_LO = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam logic [15:0] PC_RESET  = 16'h0000;
   localparam logic [15:0] PC_STEP   = 16'd2;

   // Instructions are 16-bit aligned, so any jump target is forced even.
   function automatic logic [15:0] even_addr(input logic [15:0] addr);
      return addr & 16'hFFFE;
   endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Per-byte wait timer for the fetch unit: a down-counter reloaded whenever
// the bus is not stalled, flagging the cycle in which the wait budget runs out.
module fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_in,
   input  logic reset_n_in,
   input  logic wait_in,
   input  logic ack_in,
   output logic expired_out
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   // Terminal count: this is the last stalled cycle the unit will tolerate.
   assign expired_out = wait_in && !ack_in && (cnt_q == CNT_TC);

   // Reload whenever no stall is in progress, otherwise count down.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         cnt_q <= CNT_LOAD;
      end else if (!wait_in || ack_in || expired_out) begin
         cnt_q <= CNT_LOAD;
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads a 16-bit big-endian instruction as two byte
// reads from a byte-wide memory and hands it to the instruction register.
// Optional build macro FETCH_TIMEOUT_EN adds a per-byte ack timeout that
// delivers a NOP and sets a sticky error flag.
//
//   state | meaning
//   IDLE  | waiting for fetch_req_in; PC loads accepted directly
//   RD_HI | reading high byte at pc_out
//   RD_LO | reading low byte at pc_out+1 (request re-raised after a gap cycle)
//   DONE  | update PC (pending jump, direct jump or +2) and pulse IR write
module instr_fetch_unit
   import tiny_cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        fetch_req_in,
   input  logic        pc_load_en_in,
   input  logic [15:0] pc_load_data_in,
   output logic        mem_req_out,
   output logic [15:0] mem_addr_out,
   input  logic        mem_ack_in,
   input  logic [7:0]  mem_data_in,
   output logic        ir_write_en_out,
   output logic [15:0] ir_data_out,
   output logic [15:0] pc_out,
   output logic        busy_out,
   output logic        fetch_err_out
);

   fetch_state_t state_q, state_n;
   logic [15:0]  pc_q, pc_n;
   logic [15:0]  ir_q, ir_n;
   logic [15:0]  addr_q, addr_n;
   logic         req_q, req_n;
   logic         we_q, we_n;
   logic         pend_q, pend_n;
   logic [15:0]  pend_pc_q, pend_pc_n;
   logic [15:0]  load_tgt;
   logic         ack_seen;
   logic         wd_expired;

   assign load_tgt = even_addr(pc_load_data_in);
   // Only an ack answering a live request counts, so a lingering ack from
   // the previous byte cannot be captured twice.
   assign ack_seen = req_q && mem_ack_in;

`ifdef FETCH_TIMEOUT_EN
   logic wd_wait;
   logic err_q;

   assign wd_wait = req_q && ((state_q == RD_HI) || (state_q == RD_LO));

   fetch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_in      (clk_in),
      .reset_n_in  (reset_n_in),
      .wait_in     (wd_wait),
      .ack_in      (mem_ack_in),
      .expired_out (wd_expired)
   );

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         err_q <= 1'b0;
      end else if (wd_expired) begin
         err_q <= 1'b1;
      end
   end

   assign fetch_err_out = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign wd_expired         = 1'b0;
   assign fetch_err_out      = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q   <= IDLE;
         pc_q      <= PC_RESET;
         ir_q      <= NOP_INSTR;
         addr_q    <= 16'h0000;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         pend_q    <= 1'b0;
         pend_pc_q <= PC_RESET;
      end else begin
         state_q   <= state_n;
         pc_q      <= pc_n;
         ir_q      <= ir_n;
         addr_q    <= addr_n;
         req_q     <= req_n;
         we_q      <= we_n;
         pend_q    <= pend_n;
         pend_pc_q <= pend_pc_n;
      end
   end

   // Next-state and next-output logic for the byte-read sequence.
   always_comb begin
      state_n   = state_q;
      pc_n      = pc_q;
      ir_n      = ir_q;
      addr_n    = addr_q;
      req_n     = req_q;
      we_n      = 1'b0;
      pend_n    = pend_q;
      pend_pc_n = pend_pc_q;

      case (state_q)
         IDLE: begin
            if (pc_load_en_in) begin
               pc_n = load_tgt;
            end
            if (fetch_req_in) begin
               state_n = RD_HI;
               req_n   = 1'b1;
               addr_n  = pc_load_en_in ? load_tgt : pc_q;
            end
         end

         RD_HI: begin
            if (pc_load_en_in) begin
               pend_n    = 1'b1;
               pend_pc_n = load_tgt;
            end
            if (ack_seen) begin
               ir_n[15:8] = mem_data_in;
               state_n    = RD_LO;
               req_n      = 1'b0;
               addr_n     = pc_q + 16'd1;
            end else if (wd_expired) begin
               ir_n    = NOP_INSTR;
               req_n   = 1'b0;
               state_n = DONE;
            end
         end

         RD_LO: begin
            if (pc_load_en_in) begin
               pend_n    = 1'b1;
               pend_pc_n = load_tgt;
            end
            if (!req_q) begin
               req_n = 1'b1;
            end else if (mem_ack_in) begin
               ir_n[7:0] = mem_data_in;
               state_n   = DONE;
               req_n     = 1'b0;
            end else if (wd_expired) begin
               ir_n    = NOP_INSTR;
               req_n   = 1'b0;
               state_n = DONE;
            end
         end

         DONE: begin
            state_n = IDLE;
            pend_n  = 1'b0;
            we_n    = !pend_q;
            if (pc_load_en_in) begin
               pc_n = load_tgt;
            end else if (pend_q) begin
               pc_n = pend_pc_q;
            end else begin
               pc_n = pc_q + PC_STEP;
            end
         end

         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
         end
      endcase
   end

   assign mem_req_out     = req_q;
   assign mem_addr_out    = addr_q;
   assign ir_write_en_out = we_q;
   assign ir_data_out     = ir_q;
   assign pc_out          = pc_q;
   assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory model whose ack
// latency is programmable per test.
module tb_instr_fetch_unit;

   localparam int TO_CYC = 255;

   logic        clk_in = 1'b0;
   logic        reset_n_in = 1'b0;
   logic        fetch_req_in = 1'b0;
   logic        pc_load_en_in = 1'b0;
   logic [15:0] pc_load_data_in = 16'h0000;
   logic        mem_req_out;
   logic [15:0] mem_addr_out;
   logic        mem_ack_in;
   logic [7:0]  mem_data_in;
   logic        ir_write_en_out;
   logic [15:0] ir_data_out;
   logic [15:0] pc_out;
   logic        busy_out;
   logic        fetch_err_out;

   logic [7:0] mem [0:65535];
   int  wait_cnt = 0;
   int  ack_delay = 0;
   bit  ack_en = 1'b1;
   int  tests_run = 0;
   int  fail_cnt = 0;

   instr_fetch_unit #(
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk_in          (clk_in),
      .reset_n_in      (reset_n_in),
      .fetch_req_in    (fetch_req_in),
      .pc_load_en_in   (pc_load_en_in),
      .pc_load_data_in (pc_load_data_in),
      .mem_req_out     (mem_req_out),
      .mem_addr_out    (mem_addr_out),
      .mem_ack_in      (mem_ack_in),
      .mem_data_in     (mem_data_in),
      .ir_write_en_out (ir_write_en_out),
      .ir_data_out     (ir_data_out),
      .pc_out          (pc_out),
      .busy_out        (busy_out),
      .fetch_err_out   (fetch_err_out)
   );

   always #5 clk_in = ~clk_in;

   assign mem_ack_in  = ack_en && mem_req_out && (wait_cnt >= ack_delay);
   assign mem_data_in = mem[mem_addr_out];

   always @(posedge clk_in) begin
      wait_cnt <= (!mem_req_out || mem_ack_in) ? 0 : wait_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Raise fetch_req for one cycle and wait for the IR write pulse.
   // lat = clock edges from request to pulse (0 if the budget ran out).
   task automatic do_fetch(input int max_cyc, output int lat,
                           output logic [15:0] first_addr, output int unstable);
      logic        prev_req;
      logic        prev_ack;
      logic [15:0] prev_addr;
      bit          seen_req;
      lat        = 0;
      first_addr = 16'h0000;
      unstable   = 0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      prev_addr  = 16'h0000;
      seen_req   = 1'b0;
      fetch_req_in = 1'b1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk_in);
         #1;
         if (c == 1) fetch_req_in = 1'b0;
         if (mem_req_out && !seen_req) begin
            first_addr = mem_addr_out;
            seen_req   = 1'b1;
         end
         if (prev_req && !prev_ack && !(mem_req_out && (mem_addr_out == prev_addr))) unstable++;
         if (ir_write_en_out) begin
            lat = c;
            break;
         end
         prev_req  = mem_req_out;
         prev_ack  = mem_ack_in;
         prev_addr = mem_addr_out;
      end
   endtask

   initial begin
      int          lat;
      int          unst;
      int          pulses;
      bit          loaded;
      logic [15:0] fa;

      for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
      mem[16'h0000] = 8'h12;  mem[16'h0001] = 8'h34;
      mem[16'h0002] = 8'hBE;  mem[16'h0003] = 8'hEF;
      mem[16'h0004] = 8'h11;  mem[16'h0005] = 8'h22;
      mem[16'h0100] = 8'h5A;  mem[16'h0101] = 8'hA5;
      mem[16'hFFFE] = 8'hAB;  mem[16'hFFFF] = 8'hCD;

      // Reset values
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_pc",   32'(pc_out),          32'h0000);
      chk("rst_ir",   32'(ir_data_out),     32'h0000);
      chk("rst_req",  32'(mem_req_out),     32'd0);
      chk("rst_addr", 32'(mem_addr_out),    32'h0000);
      chk("rst_we",   32'(ir_write_en_out), 32'd0);
      chk("rst_err",  32'(fetch_err_out),   32'd0);
      chk("rst_busy", 32'(busy_out),        32'd0);
      @(negedge clk_in);
      reset_n_in = 1'b1;
      @(posedge clk_in);
      #1;

      // Zero-wait fetch at 0x0000
      ack_delay = 0;
      do_fetch(50, lat, fa, unst);
      chk("f0_lat",  32'(lat),         32'd5);
      chk("f0_addr", 32'(fa),          32'h0000);
      chk("f0_ir",   32'(ir_data_out), 32'h1234);
      chk("f0_pc",   32'(pc_out),      32'h0002);
      @(posedge clk_in);
      #1;
      chk("f0_pulse_w", 32'(ir_write_en_out), 32'd0);

      // Three wait states per byte
      ack_delay = 3;
      do_fetch(50, lat, fa, unst);
      chk("f1_lat",    32'(lat),         32'd11);
      chk("f1_stable", 32'(unst),        32'd0);
      chk("f1_addr",   32'(fa),          32'h0002);
      chk("f1_ir",     32'(ir_data_out), 32'hBEEF);
      chk("f1_pc",     32'(pc_out),      32'h0004);
      repeat (4) @(posedge clk_in);
      #1;
      chk("f1_ir_hold", 32'(ir_data_out), 32'hBEEF);

      // Jump arriving during RD_LO is held pending, IR write suppressed
      pulses = 0;
      loaded = 1'b0;
      fetch_req_in = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk_in);
         #1;
         if (c == 1) fetch_req_in = 1'b0;
         if (ir_write_en_out) pulses++;
         if (!busy_out) break;
         if (!loaded && (mem_addr_out == 16'h0005)) begin
            pc_load_en_in   = 1'b1;
            pc_load_data_in = 16'h0101;
            loaded          = 1'b1;
         end else begin
            pc_load_en_in = 1'b0;
         end
      end
      pc_load_en_in = 1'b0;
      chk("jmp_loaded", 32'(loaded),  32'd1);
      chk("jmp_pulses", 32'(pulses),  32'd0);
      chk("jmp_pc",     32'(pc_out),  32'h0100);
      chk("jmp_busy",   32'(busy_out), 32'd0);
      ack_delay = 0;
      do_fetch(50, lat, fa, unst);
      chk("jmp_f_addr", 32'(fa),          32'h0100);
      chk("jmp_f_lat",  32'(lat),         32'd5);
      chk("jmp_f_ir",   32'(ir_data_out), 32'h5AA5);
      chk("jmp_f_pc",   32'(pc_out),      32'h0102);

      // Jump in IDLE with odd target, then wrap from 0xFFFE
      pc_load_en_in   = 1'b1;
      pc_load_data_in = 16'hFFFF;
      @(posedge clk_in);
      #1;
      pc_load_en_in = 1'b0;
      chk("idle_jmp_pc", 32'(pc_out), 32'hFFFE);
      do_fetch(50, lat, fa, unst);
      chk("wrap_addr", 32'(fa),          32'hFFFE);
      chk("wrap_lat",  32'(lat),         32'd5);
      chk("wrap_ir",   32'(ir_data_out), 32'hABCD);
      chk("wrap_pc",   32'(pc_out),      32'h0000);

`ifdef FETCH_TIMEOUT_EN
      // No ack: timeout delivers a NOP and flags the error
      ack_en = 1'b0;
      do_fetch(600, lat, fa, unst);
      chk("to_lat", 32'(lat),           32'(TO_CYC + 2));
      chk("to_err", 32'(fetch_err_out), 32'd1);
      chk("to_ir",  32'(ir_data_out),   32'h0000);
      chk("to_pc",  32'(pc_out),        32'h0002);
      ack_en = 1'b1;
`else
      // No ack: the unit waits indefinitely without an error
      ack_en = 1'b0;
      fetch_req_in = 1'b1;
      @(posedge clk_in);
      #1;
      fetch_req_in = 1'b0;
      repeat (300) @(posedge clk_in);
      #1;
      chk("wait_busy", 32'(busy_out),      32'd1);
      chk("wait_req",  32'(mem_req_out),   32'd1);
      chk("wait_addr", 32'(mem_addr_out),  32'h0000);
      chk("wait_err",  32'(fetch_err_out), 32'd0);
      ack_en = 1'b1;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk_in);
         #1;
         if (ir_write_en_out) begin
            pulses++;
            break;
         end
      end
      chk("wait_done", 32'(pulses),      32'd1);
      chk("wait_ir",   32'(ir_data_out), 32'h1234);
      chk("wait_pc",   32'(pc_out),      32'h0002);
`endif

      // Reset during RD_HI abandons the fetch
      ack_en = 1'b0;
      fetch_req_in = 1'b1;
      @(posedge clk_in);
      #1;
      fetch_req_in = 1'b0;
      chk("mid_busy", 32'(busy_out),    32'd1);
      chk("mid_req",  32'(mem_req_out), 32'd1);
      chk("mid_addr", 32'(mem_addr_out), 32'h0002);
      reset_n_in = 1'b0;
      #1;
      chk("mrst_pc",   32'(pc_out),          32'h0000);
      chk("mrst_ir",   32'(ir_data_out),     32'h0000);
      chk("mrst_req",  32'(mem_req_out),     32'd0);
      chk("mrst_addr", 32'(mem_addr_out),    32'h0000);
      chk("mrst_busy", 32'(busy_out),        32'd0);
      chk("mrst_we",   32'(ir_write_en_out), 32'd0);
      chk("mrst_err",  32'(fetch_err_out),   32'd0);
      @(negedge clk_in);
      reset_n_in = 1'b1;
      ack_en     = 1'b1;
      pulses     = 0;
      repeat (10) begin
         @(posedge clk_in);
         #1;
         if (ir_write_en_out) pulses++;
      end
      chk("mrst_pulses", 32'(pulses),  32'd0);
      chk("mrst_pc2",    32'(pc_out),  32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
